sram_bank: RTL and testbench



---
 rtl/sram_bank_pkg.sv | 18 +
 rtl/sram_bank_if.sv | 31 +++
 rtl/sram_array.sv | 46 ++++
 rtl/sram_bank.sv | 126 ++++++++++++
 tb/tb_sram_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bank_pkg.sv
// sram_bank shared types and helpers.
// Controller states and width/depth helpers.
package sram_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sram_bank_if.sv
// sram_bank request/response bundle.
// master drives requests, slave answers.
interface sram_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  clear;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_be, clear,
    input  req_ready, rsp_valid,
    input  rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_be, clear,
    output req_ready, rsp_valid,
    output rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_array.sv
// Byte-writable storage, one shared port.
// Read data register updates only on reads.
module sram_array
  import sram_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);
  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte-masked write; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Capture the addressed word on a read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sram_bank.sv
// sram_bank: FSM, clear sweep and read pipe.
// Sweep owns the array port while in ST_CLEAR.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_bank_if.slave   bus
);
  localparam int BE_W = be_w(DATA_W);
  localparam state_e RST_ST =
    CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  if (DATA_W % 8 != 0) begin : g_bad_w
    $fatal(1, "sram_bank: DATA_W not multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $fatal(1, "sram_bank: READ_LAT must be 1 or 2");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                v1_q, v1_d;
  logic                sweep, acc, rd_acc;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata, arr_rdata;
  logic [BE_W-1:0]     arr_be;

  assign sweep  = (state_q == ST_CLEAR);
  assign acc    = bus.req_valid & ~sweep;
  assign rd_acc = acc & ~bus.req_wr;

  // Next state and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RST_ST;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arr_we    = sweep | (acc & bus.req_wr);
  assign arr_addr  = sweep ? cnt_q : bus.req_addr;
  assign arr_wdata = sweep ? '0 : bus.req_wdata;
  assign arr_be    = sweep ? '1 : bus.req_be;

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (rd_acc),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  assign v1_d = rd_acc;

  // First-stage response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1_q <= 1'b0;
    else        v1_q <= v1_d;
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] out_q, out_d;

    // Extra output stage, holds data when idle.
    always_comb begin
      v2_d  = v1_q;
      out_d = v1_q ? arr_rdata : out_q;
    end

    // Second-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q  <= 1'b0;
        out_q <= '0;
      end else begin
        v2_q  <= v2_d;
        out_q <= out_d;
      end
    end

    assign bus.rsp_valid = v2_q;
    assign bus.rsp_rdata = out_q;
  end else begin : g_lat1
    assign bus.rsp_valid = v1_q;
    assign bus.rsp_rdata = arr_rdata;
  end

  assign bus.req_ready = ~sweep;
  assign bus.init_done = ~sweep;
endmodule

// File: tb/tb_sram_bank.sv
// Directed bench for sram_bank.
// u1: LAT1/clear-on-reset, u2: LAT2, u3: no reset sweep.
module tb_sram_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr, clear;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sram_bank_if #(.DATA_W(16), .ADDR_W(4)) b1 ();
  sram_bank_if #(.DATA_W(16), .ADDR_W(4)) b2 ();
  sram_bank_if #(.DATA_W(16), .ADDR_W(4)) b3 ();

  assign b1.req_valid = req_valid;
  assign b1.req_wr    = req_wr;
  assign b1.req_addr  = req_addr;
  assign b1.req_wdata = req_wdata;
  assign b1.req_be    = req_be;
  assign b1.clear     = clear;
  assign b2.req_valid = req_valid;
  assign b2.req_wr    = req_wr;
  assign b2.req_addr  = req_addr;
  assign b2.req_wdata = req_wdata;
  assign b2.req_be    = req_be;
  assign b2.clear     = clear;
  assign b3.req_valid = req_valid;
  assign b3.req_wr    = req_wr;
  assign b3.req_addr  = req_addr;
  assign b3.req_wdata = req_wdata;
  assign b3.req_be    = req_be;
  assign b3.clear     = clear;

  sram_bank #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1),
              .CLEAR_ON_RESET(1'b1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  sram_bank #(.DATA_W(16), .ADDR_W(4), .READ_LAT(2),
              .CLEAR_ON_RESET(1'b1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  sram_bank #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1),
              .CLEAR_ON_RESET(1'b0))
    u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [15:0] d,
                    input logic [1:0] be);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_wr    = 1'b0;
  endtask

  task automatic rd_issue(input logic [3:0] a);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    clear     = 1'b0;
    step();
    step();

    // reset values
    chk("rst_rdy1",  b1.req_ready, 0);
    chk("rst_init1", b1.init_done, 0);
    chk("rst_v1",    b1.rsp_valid, 0);
    chk("rst_d1",    b1.rsp_rdata, 16'h0);
    chk("rst_v2",    b2.rsp_valid, 0);
    chk("rst_d2",    b2.rsp_rdata, 16'h0);
    chk("rst_rdy3",  b3.req_ready, 1);
    chk("rst_init3", b3.init_done, 1);

    // initial sweep: 16 cycles not ready
    rst_n = 1'b1;
    chk("rel_rdy3", b3.req_ready, 1);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("sweep_rdy1", b1.req_ready, 0);
      chk("sweep_rdy2", b2.req_ready, 0);
    end
    step();
    chk("sweep_done1", b1.req_ready, 1);
    chk("sweep_init1", b1.init_done, 1);
    chk("sweep_done2", b2.req_ready, 1);

    // every word reads zero, back-to-back
    for (int i = 0; i < 16; i++) begin
      rd_issue(4'(i));
      step();
      chk("zero_v1", b1.rsp_valid, 1);
      chk("zero_d1", b1.rsp_rdata, 16'h0);
      if (i > 0) begin
        chk("zero_v2", b2.rsp_valid, 1);
        chk("zero_d2", b2.rsp_rdata, 16'h0);
      end
    end
    req_valid = 1'b0;
    step();
    chk("zero_end_v1", b1.rsp_valid, 0);
    chk("zero_last_v2", b2.rsp_valid, 1);
    chk("zero_last_d2", b2.rsp_rdata, 16'h0);
    step();
    chk("zero_end_v2", b2.rsp_valid, 0);

    // byte-enable merge and latency
    wr(4'd3, 16'hBEEF, 2'b11);
    wr(4'd3, 16'h12AB, 2'b10);
    rd_issue(4'd3);
    step();
    req_valid = 1'b0;
    chk("be_v1", b1.rsp_valid, 1);
    chk("be_d1", b1.rsp_rdata, 16'h12EF);
    chk("be_v2_early", b2.rsp_valid, 0);
    chk("be_d3", b3.rsp_rdata, 16'h12EF);
    step();
    chk("be_v1_off", b1.rsp_valid, 0);
    chk("be_d1_hold", b1.rsp_rdata, 16'h12EF);
    chk("be_v2", b2.rsp_valid, 1);
    chk("be_d2", b2.rsp_rdata, 16'h12EF);

    // write then immediate back-to-back reads
    wr(4'd7, 16'hA5A5, 2'b11);
    rd_issue(4'd7);
    step();
    chk("b2b_d1_7", b1.rsp_rdata, 16'hA5A5);
    chk("b2b_d3_7", b3.rsp_rdata, 16'hA5A5);
    rd_issue(4'd3);
    step();
    chk("b2b_d1_3", b1.rsp_rdata, 16'h12EF);
    chk("b2b_d2_7", b2.rsp_rdata, 16'hA5A5);
    rd_issue(4'd0);
    step();
    req_valid = 1'b0;
    chk("b2b_v1_0", b1.rsp_valid, 1);
    chk("b2b_d1_0", b1.rsp_rdata, 16'h0);
    chk("b2b_d2_3", b2.rsp_rdata, 16'h12EF);
    step();
    chk("b2b_v1_end", b1.rsp_valid, 0);
    chk("b2b_v2_0", b2.rsp_valid, 1);
    chk("b2b_d2_0", b2.rsp_rdata, 16'h0);

    // read accepted with clear returns pre-clear data
    rd_issue(4'd7);
    clear = 1'b1;
    step();
    req_valid = 1'b0;
    clear     = 1'b0;
    chk("clr_rd_v1", b1.rsp_valid, 1);
    chk("clr_rd_d1", b1.rsp_rdata, 16'hA5A5);
    chk("clr_rdy1", b1.req_ready, 0);
    chk("clr_rdy3", b3.req_ready, 0);
    chk("clr_init3", b3.init_done, 0);
    step();
    chk("clr_rd_v2", b2.rsp_valid, 1);
    chk("clr_rd_d2", b2.rsp_rdata, 16'hA5A5);
    for (int i = 2; i < 16; i++) begin
      if (i == 5) clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_sweep1", b1.req_ready, 0);
      chk("clr_sweep3", b3.req_ready, 0);
    end
    step();
    chk("clr_done1", b1.req_ready, 1);
    chk("clr_done3", b3.req_ready, 1);

    // clear together with a write
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 16'h5555;
    req_be    = 2'b11;
    clear     = 1'b1;
    step();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    clear     = 1'b0;
    chk("clrw_rdy1", b1.req_ready, 0);
    for (int i = 1; i < 16; i++) step();
    chk("clrw_busy1", b1.req_ready, 0);
    step();
    chk("clrw_done1", b1.req_ready, 1);
    rd_issue(4'd2);
    step();
    req_valid = 1'b0;
    chk("clrw_d1", b1.rsp_rdata, 16'h0);
    chk("clrw_d3", b3.rsp_rdata, 16'h0);

    // reset during a LAT2 burst
    wr(4'd3, 16'h1234, 2'b11);
    rd_issue(4'd3);
    step();
    rd_issue(4'd3);
    step();
    chk("burst_v2", b2.rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v2", b2.rsp_valid, 0);
    chk("mid_rst_d2", b2.rsp_rdata, 16'h0);
    chk("mid_rst_v1", b1.rsp_valid, 0);
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rerel_rdy3", b3.req_ready, 1);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("stale_v1", b1.rsp_valid, 0);
      chk("stale_v2", b2.rsp_valid, 0);
      chk("resweep_rdy2", b2.req_ready, 0);
    end
    step();
    chk("resweep_done1", b1.req_ready, 1);
    chk("resweep_done2", b2.req_ready, 1);
    rd_issue(4'd3);
    step();
    req_valid = 1'b0;
    chk("post_d1", b1.rsp_rdata, 16'h0);
    chk("post_d3", b3.rsp_rdata, 16'h1234);
    step();
    chk("post_v2", b2.rsp_valid, 1);
    chk("post_d2", b2.rsp_rdata, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
